instr_decode: RTL and testbench

INSTR_DECODE -- requirements
Module: instr_decode

---
 rtl/isa_pkg.sv | 58 +++++
 rtl/instr_fields.sv | 94 +++++++++
 rtl/instr_decode.sv | 125 ++++++++++++
 tb/tb_instr_decode.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcode encodings, instruction field positions and
// the decoded bundle type used by decode and the ALU.
package isa_pkg;

   typedef enum logic [3:0] {
      OP_ADD    = 4'h0,
      OP_PADDSB = 4'h1,
      OP_SUB    = 4'h2,
      OP_AND    = 4'h3,
      OP_NOR    = 4'h4,
      OP_SLL    = 4'h5,
      OP_SRL    = 4'h6,
      OP_SRA    = 4'h7,
      OP_LW     = 4'h8,
      OP_SW     = 4'h9,
      OP_LHB    = 4'hA,
      OP_LLB    = 4'hB,
      OP_B      = 4'hC,
      OP_JAL    = 4'hD,
      OP_JR     = 4'hE,
      OP_HLT    = 4'hF
   } opcode_e;

   localparam int unsigned OPC_HI  = 15;
   localparam int unsigned OPC_LO  = 12;
   localparam int unsigned RD_HI   = 11;
   localparam int unsigned RD_LO   = 8;
   localparam int unsigned RS_HI   = 7;
   localparam int unsigned RS_LO   = 4;
   localparam int unsigned RT_HI   = 3;
   localparam int unsigned RT_LO   = 0;
   localparam int unsigned COND_HI = 11;
   localparam int unsigned COND_LO = 9;
   localparam int unsigned BOFF_HI = 8;
   localparam int unsigned JOFF_HI = 11;
   localparam int unsigned BYTE_HI = 7;

   localparam logic [3:0] LINK_REG = 4'hF;

   typedef struct packed {
      logic [3:0]  alu_op;
      logic [3:0]  rd;
      logic [3:0]  rs;
      logic [3:0]  rt;
      logic [15:0] imm;
      logic [2:0]  cond;
      logic        reg_we;
      logic        mem_re;
      logic        mem_we;
      logic        is_branch;
      logic        is_jal;
      logic        is_jr;
      logic        halt;
      logic        reads_rs;
      logic        reads_rt;
   } decode_t;

endpackage

// File: rtl/instr_fields.sv
// Combinational field extraction and immediate formatting for one
// instruction word; also reports which source registers are really read.
module instr_fields
   import isa_pkg::*;
(
   input  logic [15:0] instr,
   output decode_t     dec
);

   opcode_e    op;
   logic [3:0] f_hi;
   logic [3:0] f_mid;
   logic [3:0] f_lo;

   assign op    = opcode_e'(instr[OPC_HI:OPC_LO]);
   assign f_hi  = instr[RD_HI:RD_LO];
   assign f_mid = instr[RS_HI:RS_LO];
   assign f_lo  = instr[RT_HI:RT_LO];

   always_comb begin
      dec        = '0;
      dec.alu_op = instr[OPC_HI:OPC_LO];
      case (op)
         OP_ADD, OP_PADDSB, OP_SUB, OP_AND, OP_NOR: begin
            dec.rd       = f_hi;
            dec.rs       = f_mid;
            dec.rt       = f_lo;
            dec.reg_we   = 1'b1;
            dec.reads_rs = 1'b1;
            dec.reads_rt = 1'b1;
         end
         // the rt field of a shift is the shift amount, not a register read
         OP_SLL, OP_SRL, OP_SRA: begin
            dec.rd       = f_hi;
            dec.rs       = f_mid;
            dec.rt       = f_lo;
            dec.imm      = {12'h000, f_lo};
            dec.reg_we   = 1'b1;
            dec.reads_rs = 1'b1;
         end
         OP_LW: begin
            dec.rd       = f_hi;
            dec.rs       = f_mid;
            dec.imm      = {{(15 - RT_HI){instr[RT_HI]}}, f_lo};
            dec.reg_we   = 1'b1;
            dec.mem_re   = 1'b1;
            dec.reads_rs = 1'b1;
         end
         OP_SW: begin
            dec.rs       = f_mid;
            dec.rt       = f_hi;
            dec.imm      = {{(15 - RT_HI){instr[RT_HI]}}, f_lo};
            dec.mem_we   = 1'b1;
            dec.reads_rs = 1'b1;
            dec.reads_rt = 1'b1;
         end
         OP_LHB: begin
            dec.rd       = f_hi;
            dec.rs       = f_hi;
            dec.imm      = {8'h00, instr[BYTE_HI:0]};
            dec.reg_we   = 1'b1;
            dec.reads_rs = 1'b1;
         end
         OP_LLB: begin
            dec.rd     = f_hi;
            dec.imm    = {{(15 - BYTE_HI){instr[BYTE_HI]}}, instr[BYTE_HI:0]};
            dec.reg_we = 1'b1;
         end
         OP_B: begin
            dec.cond      = instr[COND_HI:COND_LO];
            dec.imm       = {{(15 - BOFF_HI){instr[BOFF_HI]}}, instr[BOFF_HI:0]};
            dec.is_branch = 1'b1;
         end
         OP_JAL: begin
            dec.rd      = LINK_REG;
            dec.imm     = {{(15 - JOFF_HI){instr[JOFF_HI]}}, instr[JOFF_HI:0]};
            dec.reg_we  = 1'b1;
            dec.is_jal  = 1'b1;
         end
         OP_JR: begin
            dec.rs       = f_mid;
            dec.is_jr    = 1'b1;
            dec.reads_rs = 1'b1;
         end
         default: begin
            dec.halt = 1'b1;
         end
      endcase
      if (dec.rd == 4'h0 && !dec.is_jal) begin
         dec.reg_we = 1'b0;
      end
   end

endmodule

// File: rtl/instr_decode.sv
// Decode stage: registers one decoded bundle with valid/ready handshaking,
// load-use hazard stall, flush, and a sticky halt state.
module instr_decode
   import isa_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_valid,
   input  logic [15:0] if_instr,
   input  logic [15:0] if_pc,
   output logic        id_ready,
   input  logic        flush,
   input  logic        ex_ready,
   input  logic        ex_load_valid,
   input  logic [3:0]  ex_load_rd,
   output logic        id_valid,
   output logic [3:0]  alu_op,
   output logic [3:0]  rs_addr,
   output logic [3:0]  rt_addr,
   output logic [3:0]  rd_addr,
   output logic [15:0] imm,
   output logic        reg_we,
   output logic        mem_re,
   output logic        mem_we,
   output logic        is_branch,
   output logic        is_jal,
   output logic        is_jr,
   output logic        halt,
   output logic [2:0]  cond,
   output logic [15:0] pc_out
);

   typedef enum logic {
      ST_RUN,
      ST_HALTED
   } state_e;

   state_e  state;
   state_e  state_nxt;
   logic    halted;
   logic    hold_hlt;
   logic    hazard;
   logic    accept;
   decode_t dec;

   instr_fields u_fields (
      .instr (if_instr),
      .dec   (dec)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // a HLT squashed by flush in its departing cycle never halts the core
   always_comb begin
      state_nxt = state;
      if (state == ST_RUN && id_valid && ex_ready && halt && !flush) begin
         state_nxt = ST_HALTED;
      end
   end

   always_comb begin
      halted = 1'b0;
      if (state == ST_HALTED) begin
         halted = 1'b1;
      end
   end

   assign hold_hlt = id_valid && halt;

   assign hazard = if_valid && ex_load_valid && (ex_load_rd != 4'h0) &&
                   ((dec.reads_rs && dec.rs == ex_load_rd) ||
                    (dec.reads_rt && dec.rt == ex_load_rd));

   assign id_ready = rst_n && !halted && !flush && !hold_hlt && !hazard &&
                     (!id_valid || ex_ready);

   assign accept = if_valid && id_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         id_valid  <= 1'b0;
         alu_op    <= '0;
         rs_addr   <= '0;
         rt_addr   <= '0;
         rd_addr   <= '0;
         imm       <= '0;
         reg_we    <= 1'b0;
         mem_re    <= 1'b0;
         mem_we    <= 1'b0;
         is_branch <= 1'b0;
         is_jal    <= 1'b0;
         is_jr     <= 1'b0;
         halt      <= 1'b0;
         cond      <= '0;
         pc_out    <= '0;
      end else if (flush) begin
         id_valid <= 1'b0;
      end else if (accept) begin
         id_valid  <= 1'b1;
         alu_op    <= dec.alu_op;
         rs_addr   <= dec.rs;
         rt_addr   <= dec.rt;
         rd_addr   <= dec.rd;
         imm       <= dec.imm;
         reg_we    <= dec.reg_we;
         mem_re    <= dec.mem_re;
         mem_we    <= dec.mem_we;
         is_branch <= dec.is_branch;
         is_jal    <= dec.is_jal;
         is_jr     <= dec.is_jr;
         halt      <= dec.halt;
         cond      <= dec.cond;
         pc_out    <= if_pc;
      end else if (ex_ready) begin
         id_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_instr_decode.sv
// Self-checking bench for instr_decode: directed table, randomized traffic
// against an abstract decode model, and hand-written hazard/stall/halt runs.
module tb_instr_decode;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_valid;
   logic [15:0] if_instr;
   logic [15:0] if_pc;
   logic        id_ready;
   logic        flush;
   logic        ex_ready;
   logic        ex_load_valid;
   logic [3:0]  ex_load_rd;
   logic        id_valid;
   logic [3:0]  alu_op;
   logic [3:0]  rs_addr;
   logic [3:0]  rt_addr;
   logic [3:0]  rd_addr;
   logic [15:0] imm;
   logic        reg_we;
   logic        mem_re;
   logic        mem_we;
   logic        is_branch;
   logic        is_jal;
   logic        is_jr;
   logic        halt;
   logic [2:0]  cond;
   logic [15:0] pc_out;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   instr_decode dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .if_valid      (if_valid),
      .if_instr      (if_instr),
      .if_pc         (if_pc),
      .id_ready      (id_ready),
      .flush         (flush),
      .ex_ready      (ex_ready),
      .ex_load_valid (ex_load_valid),
      .ex_load_rd    (ex_load_rd),
      .id_valid      (id_valid),
      .alu_op        (alu_op),
      .rs_addr       (rs_addr),
      .rt_addr       (rt_addr),
      .rd_addr       (rd_addr),
      .imm           (imm),
      .reg_we        (reg_we),
      .mem_re        (mem_re),
      .mem_we        (mem_we),
      .is_branch     (is_branch),
      .is_jal        (is_jal),
      .is_jr         (is_jr),
      .halt          (halt),
      .cond          (cond),
      .pc_out        (pc_out)
   );

   // flags = {reg_we, mem_re, mem_we, is_branch, is_jal, is_jr, halt}
   // mask  = {cond, imm, rd, rt, rs}: which fields carry a defined value
   typedef struct {
      logic [15:0] instr;
      logic [3:0]  alu_op;
      logic [3:0]  rd;
      logic [3:0]  rs;
      logic [3:0]  rt;
      logic [15:0] imm;
      logic [2:0]  cond;
      logic [6:0]  flags;
      logic [4:0]  mask;
      logic        src_rs;
      logic        src_rt;
   } exp_t;

   function automatic exp_t mk(input logic [15:0] ins, input logic [3:0] a,
                               input logic [3:0] d, input logic [3:0] s,
                               input logic [3:0] t, input logic [15:0] im,
                               input logic [2:0] c, input logic [6:0] f,
                               input logic [4:0] m);
      exp_t e;
      e.instr = ins; e.alu_op = a; e.rd = d; e.rs = s; e.rt = t;
      e.imm = im; e.cond = c; e.flags = f; e.mask = m;
      e.src_rs = 1'b0; e.src_rt = 1'b0;
      return e;
   endfunction

   function automatic logic [15:0] sx(input int v, input int bits);
      int r;
      r = v;
      if (r >= (1 << (bits - 1))) r = r - (1 << bits);
      return 16'(r);
   endfunction

   // reference decode computed straight from the instruction-set rules
   function automatic exp_t model(input logic [15:0] ins);
      exp_t e;
      int   op, w, fa, fb, fc;
      logic wr;
      w  = int'(ins);
      op = w / 4096;
      fa = (w / 256) % 16;
      fb = (w / 16) % 16;
      fc = w % 16;
      e  = mk(ins, 4'(op), 4'h0, 4'h0, 4'h0, 16'h0000, 3'd0, 7'b0, 5'b0);
      wr = 1'b0;
      if (op <= 7) begin
         e.rd = 4'(fa); e.rs = 4'(fb); e.rt = 4'(fc);
         e.mask = 5'h07; wr = 1'b1; e.src_rs = 1'b1;
         if (op >= 5) begin
            e.imm = 16'(fc); e.mask[3] = 1'b1;
         end else begin
            e.src_rt = 1'b1;
         end
      end else begin
         case (op)
            8: begin
               e.rd = 4'(fa); e.rs = 4'(fb); e.imm = sx(fc, 4);
               e.mask = 5'h0D; wr = 1'b1; e.src_rs = 1'b1; e.flags[5] = 1'b1;
            end
            9: begin
               e.rs = 4'(fb); e.rt = 4'(fa); e.imm = sx(fc, 4);
               e.mask = 5'h0B; e.src_rs = 1'b1; e.src_rt = 1'b1; e.flags[4] = 1'b1;
            end
            10: begin
               e.rd = 4'(fa); e.rs = 4'(fa); e.imm = 16'(w % 256);
               e.mask = 5'h0D; wr = 1'b1; e.src_rs = 1'b1;
            end
            11: begin
               e.rd = 4'(fa); e.imm = sx(w % 256, 8); e.mask = 5'h0C; wr = 1'b1;
            end
            12: begin
               e.cond = 3'((w % 4096) / 512); e.imm = sx(w % 512, 9);
               e.mask = 5'h18; e.flags[3] = 1'b1;
            end
            13: begin
               e.rd = 4'd15; e.imm = sx(w % 4096, 12);
               e.mask = 5'h0C; wr = 1'b1; e.flags[2] = 1'b1;
            end
            14: begin
               e.rs = 4'(fb); e.mask = 5'h01; e.src_rs = 1'b1; e.flags[1] = 1'b1;
            end
            default: e.flags[0] = 1'b1;
         endcase
      end
      e.flags[6] = wr && (e.rd != 4'h0 || op == 13);
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_bundle(input exp_t e, input logic [15:0] pc, input string tag);
      chk({tag, ".id_valid"}, 32'(id_valid), 32'd1);
      chk({tag, ".alu_op"}, 32'(alu_op), 32'(e.alu_op));
      chk({tag, ".flags"}, 32'({reg_we, mem_re, mem_we, is_branch, is_jal, is_jr, halt}),
          32'(e.flags));
      chk({tag, ".pc_out"}, 32'(pc_out), 32'(pc));
      if (e.mask[0]) chk({tag, ".rs"}, 32'(rs_addr), 32'(e.rs));
      if (e.mask[1]) chk({tag, ".rt"}, 32'(rt_addr), 32'(e.rt));
      if (e.mask[2]) chk({tag, ".rd"}, 32'(rd_addr), 32'(e.rd));
      if (e.mask[3]) chk({tag, ".imm"}, 32'(imm), 32'(e.imm));
      if (e.mask[4]) chk({tag, ".cond"}, 32'(cond), 32'(e.cond));
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".id_valid"}, 32'(id_valid), 32'd0);
      chk({tag, ".bundle"}, 32'({alu_op, rs_addr, rt_addr, rd_addr, cond, reg_we, mem_re,
                                 mem_we, is_branch, is_jal, is_jr, halt}), 32'd0);
      chk({tag, ".imm_pc"}, {imm, pc_out}, 32'd0);
   endtask

   task automatic drive(input logic v, input logic [15:0] ins, input logic exr,
                        input logic fl, input logic lv, input logic [3:0] lrd);
      if_valid      = v;
      if_instr      = ins;
      if_pc         = 16'($urandom);
      ex_ready      = exr;
      flush         = fl;
      ex_load_valid = lv;
      ex_load_rd    = lrd;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   exp_t        tbl[12];
   exp_t        m_b;
   exp_t        mo;
   logic        m_valid;
   logic        m_ready;
   logic        haz;
   logic [15:0] pc_exp;
   logic [15:0] ins;
   logic [3:0]  lrd;

   initial begin
      tbl[0]  = mk(16'h2123, 4'h2, 4'h1, 4'h2, 4'h3, 16'h0000, 3'd0, 7'b1000000, 5'h07);
      tbl[1]  = mk(16'h8A3F, 4'h8, 4'hA, 4'h3, 4'h0, 16'hFFFF, 3'd0, 7'b1100000, 5'h0D);
      tbl[2]  = mk(16'hB580, 4'hB, 4'h5, 4'h0, 4'h0, 16'hFF80, 3'd0, 7'b1000000, 5'h0C);
      tbl[3]  = mk(16'hA580, 4'hA, 4'h5, 4'h5, 4'h0, 16'h0080, 3'd0, 7'b1000000, 5'h0D);
      tbl[4]  = mk(16'h9C47, 4'h9, 4'h0, 4'h4, 4'hC, 16'h0007, 3'd0, 7'b0010000, 5'h0B);
      tbl[5]  = mk(16'h5E39, 4'h5, 4'hE, 4'h3, 4'h9, 16'h0009, 3'd0, 7'b1000000, 5'h0F);
      tbl[6]  = mk(16'h0045, 4'h0, 4'h0, 4'h4, 4'h5, 16'h0000, 3'd0, 7'b0000000, 5'h07);
      tbl[7]  = mk(16'hC501, 4'hC, 4'h0, 4'h0, 4'h0, 16'hFF01, 3'd2, 7'b0001000, 5'h18);
      tbl[8]  = mk(16'hD800, 4'hD, 4'hF, 4'h0, 4'h0, 16'hF800, 3'd0, 7'b1000100, 5'h0C);
      tbl[9]  = mk(16'hE0B0, 4'hE, 4'h0, 4'hB, 4'h0, 16'h0000, 3'd0, 7'b0000010, 5'h01);
      tbl[10] = mk(16'h7F13, 4'h7, 4'hF, 4'h1, 4'h3, 16'h0003, 3'd0, 7'b1000000, 5'h0F);
      tbl[11] = mk(16'hA0C3, 4'hA, 4'h0, 4'h0, 4'h0, 16'h00C3, 3'd0, 7'b0000000, 5'h0D);

      // reset: no acceptance, all registered outputs cleared
      rst_n = 1'b0;
      drive(1'b1, 16'h2123, 1'b1, 1'b0, 1'b0, 4'h0);
      step();
      chk("rst.id_ready", 32'(id_ready), 32'd0);
      step();
      chk("rst.id_ready2", 32'(id_ready), 32'd0);
      check_zero("rst");
      rst_n = 1'b1;

      // directed decode table, one instruction per cycle
      for (int i = 0; i < 12; i++) begin
         drive(1'b1, tbl[i].instr, 1'b1, 1'b0, 1'b0, 4'h0);
         pc_exp = if_pc;
         #1;
         chk($sformatf("tbl%0d.id_ready", i), 32'(id_ready), 32'd1);
         step();
         check_bundle(tbl[i], pc_exp, $sformatf("tbl%0d", i));
      end
      drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0);
      step();
      chk("drain.id_valid", 32'(id_valid), 32'd0);

      // randomized traffic against the reference model (HLT excluded)
      m_valid = 1'b0;
      m_b     = model(16'h0000);
      for (int k = 0; k < 400; k++) begin
         ins        = 16'($urandom);
         ins[15:12] = 4'($urandom_range(0, 14));
         case ($urandom_range(0, 3))
            0: lrd = ins[11:8];
            1: lrd = ins[7:4];
            2: lrd = ins[3:0];
            default: lrd = 4'($urandom);
         endcase
         drive($urandom_range(0, 3) != 0, ins, $urandom_range(0, 3) != 0,
               $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0, lrd);
         #1;
         mo  = model(ins);
         haz = if_valid && ex_load_valid && ex_load_rd != 4'h0 &&
               ((mo.src_rs && mo.rs == ex_load_rd) || (mo.src_rt && mo.rt == ex_load_rd));
         m_ready = !flush && !(m_valid && m_b.flags[0]) && !haz && (!m_valid || ex_ready);
         chk("rnd.id_ready", 32'(id_ready), 32'(m_ready));
         if (flush) begin
            m_valid = 1'b0;
         end else if (if_valid && m_ready) begin
            m_valid = 1'b1;
            m_b     = mo;
            pc_exp  = if_pc;
         end else if (ex_ready) begin
            m_valid = 1'b0;
         end
         step();
         if (m_valid) check_bundle(m_b, pc_exp, "rnd");
         else chk("rnd.id_valid", 32'(id_valid), 32'd0);
      end
      drive(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 4'h0);
      step();

      // load-use hazard: one stall cycle, one bubble, then accept
      drive(1'b1, 16'h8A3F, 1'b1, 1'b0, 1'b0, 4'h0);
      step();
      check_bundle(tbl[1], if_pc, "lw");
      drive(1'b1, 16'h01A2, 1'b1, 1'b0, 1'b1, 4'hA);
      #1;
      chk("haz.id_ready", 32'(id_ready), 32'd0);
      step();
      chk("haz.bubble", 32'(id_valid), 32'd0);
      drive(1'b1, 16'h01A2, 1'b1, 1'b0, 1'b0, 4'h0);
      #1;
      chk("haz.id_ready_after", 32'(id_ready), 32'd1);
      step();
      check_bundle(mk(16'h01A2, 4'h0, 4'h1, 4'hA, 4'h2, 16'h0, 3'd0, 7'b1000000, 5'h07),
                   if_pc, "haz.accept");

      // back-pressure for three cycles, flush in the third
      drive(1'b1, 16'h2123, 1'b1, 1'b0, 1'b0, 4'h0);
      pc_exp = if_pc;
      step();
      for (int c = 0; c < 3; c++) begin
         drive(1'b1, 16'h3456, 1'b0, c == 2, 1'b0, 4'h0);
         #1;
         chk($sformatf("stall%0d.id_ready", c), 32'(id_ready), 32'd0);
         step();
         if (c < 2) check_bundle(tbl[0], pc_exp, $sformatf("stall%0d", c));
         else chk("stall.flushed", 32'(id_valid), 32'd0);
      end
      drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0);
      #1;
      chk("stall.ready_back", 32'(id_ready), 32'd1);
      step();

      // HLT flushed before leaving does not halt
      drive(1'b1, 16'hF000, 1'b0, 1'b0, 1'b0, 4'h0);
      step();
      chk("hlt1.halt", 32'({id_valid, halt}), 32'd3);
      drive(1'b1, 16'h2123, 1'b0, 1'b1, 1'b0, 4'h0);
      step();
      chk("hlt1.flushed", 32'(id_valid), 32'd0);
      drive(1'b1, 16'h2123, 1'b1, 1'b0, 1'b0, 4'h0);
      #1;
      chk("hlt1.ready_back", 32'(id_ready), 32'd1);
      step();
      chk("hlt1.next", 32'({id_valid, halt}), 32'd2);

      // HLT that leaves halts until reset
      drive(1'b1, 16'hF000, 1'b1, 1'b0, 1'b0, 4'h0);
      step();
      chk("hlt2.halt", 32'({id_valid, halt}), 32'd3);
      drive(1'b1, 16'h2123, 1'b1, 1'b0, 1'b0, 4'h0);
      #1;
      chk("hlt2.hold", 32'(id_ready), 32'd0);
      step();
      chk("hlt2.left", 32'(id_valid), 32'd0);
      for (int c = 0; c < 4; c++) begin
         #1;
         chk($sformatf("halted%0d.id_ready", c), 32'(id_ready), 32'd0);
         step();
         chk($sformatf("halted%0d.id_valid", c), 32'(id_valid), 32'd0);
      end
      rst_n = 1'b0;
      #1;
      chk("hrst.id_ready", 32'(id_ready), 32'd0);
      step();
      check_zero("hrst");
      rst_n = 1'b1;
      #1;
      chk("hrst.ready_back", 32'(id_ready), 32'd1);
      pc_exp = if_pc;
      step();
      check_bundle(tbl[0], pc_exp, "hrst.accept");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
